regfile_wb_scheduler: RTL and testbench

Write-port scheduler and hazard scoreboard for the 16×24-bit register file in the decode stage. It shares the register file's single write port among three writeback requesters (ALU, memory, multiplier) using round-robin arbitration, and drives the file's write-enable, select and data from registers. It tracks destination registers with writes still outstanding and stalls decode-stage issue on RAW and WAW hazards.

---
 rtl/regfile_wb_scheduler_pkg.sv | 13 +
 rtl/regfile_wb_scheduler_if.sv | 14 +
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 35 +++
 rtl/regfile_wb_scheduler.sv | 95 +++++++++
 tb/tb_regfile_wb_scheduler.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and requester ids for the register-file write-port scheduler.
package regfile_ctrl_pkg;
    localparam int DW   = 24;
    localparam int AW   = 4;
    localparam int NREG = 16;
    localparam int NREQ = 3;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_MEM = 2'd1,
        REQ_MUL = 2'd2
    } req_id_t;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request bus: per-requester valid/addr/data with a one-hot grant back.
interface regfile_wb_if #(
    parameter int NREQ = 3,
    parameter int AW   = 4,
    parameter int DW   = 24
) ();
    logic [NREQ-1:0]    wb_valid;
    logic [NREQ*AW-1:0] wb_addr;
    logic [NREQ*DW-1:0] wb_data;
    logic [NREQ-1:0]    wb_ready;

    modport master (output wb_valid, wb_addr, wb_data, input wb_ready);
    modport slave  (input wb_valid, wb_addr, wb_data, output wb_ready);
endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: search begins one past the last granted requester.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [IW-1:0] grant_idx;
    int            idx;

    always_comb begin
        grant     = '0;
        grant_idx = last_grant_q;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant_q) + k) % N;
            if (req[idx] && (grant == '0)) begin
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
        last_grant_d = accept ? grant_idx : last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) last_grant_q <= IW'(N - 1);
        else        last_grant_q <= last_grant_d;
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port among writeback requesters and
// stalls decode issue on RAW/WAW hazards against outstanding writes.
module regfile_wb_scheduler #(
    parameter int NREQ = regfile_ctrl_pkg::NREQ,
    parameter int DW   = regfile_ctrl_pkg::DW,
    parameter int AW   = regfile_ctrl_pkg::AW,
    parameter int NREG = regfile_ctrl_pkg::NREG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic [AW-1:0]   issue_rs3,
    input  logic [2:0]      issue_use,
    output logic            stall,
    regfile_wb_if.slave     wb,
    output logic            regwBoolean,
    output logic [AW-1:0]   rwselector,
    output logic [DW-1:0]   rwdata,
    output logic [NREG-1:0] pending
);
    import regfile_ctrl_pkg::*;

    logic [NREQ-1:0] grant;
    logic            accept;
    logic            issue_acc;
    logic            src_hit;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic            wr_en_q,   wr_en_d;
    logic [AW-1:0]   wr_sel_q,  wr_sel_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [NREG-1:0] pending_q, pending_d;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (wb.wb_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign wb.wb_ready = reset ? grant : '0;
    assign accept      = |(wb.wb_valid & wb.wb_ready);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (wb.wb_ready[i]) begin
                sel_addr = wb.wb_addr[i*AW +: AW];
                sel_data = wb.wb_data[i*DW +: DW];
            end
        end
    end

    // No bypass from the write port: hazards resolve only once pending clears.
    assign src_hit   = (issue_use[0] && pending_q[issue_rs1]) ||
                       (issue_use[1] && pending_q[issue_rs2]) ||
                       (issue_use[2] && pending_q[issue_rs3]);
    assign stall     = reset && issue_valid && (pending_q[issue_rd] || src_hit);
    assign issue_acc = issue_valid && !stall;

    always_comb begin
        wr_en_d   = accept;
        wr_sel_d  = accept ? sel_addr : wr_sel_q;
        wr_data_d = accept ? sel_data : wr_data_q;
        pending_d = pending_q;
        if (wr_en_q)   pending_d[wr_sel_q] = 1'b0;
        // Set after clear so a same-cycle issue to the written register wins.
        if (issue_acc) pending_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

    assign regwBoolean = wr_en_q;
    assign rwselector  = wr_sel_q;
    assign rwdata      = wr_data_q;
    assign pending     = pending_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized bench for regfile_wb_scheduler against a behavioural scoreboard model.
module tb_regfile_wb_scheduler;
    localparam int NREQ = 3;
    localparam int DW   = 24;
    localparam int AW   = 4;
    localparam int NREG = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd, issue_rs1, issue_rs2, issue_rs3;
    logic [2:0]      issue_use;
    logic            stall;
    logic            regwBoolean;
    logic [AW-1:0]   rwselector;
    logic [DW-1:0]   rwdata;
    logic [NREG-1:0] pending;

    regfile_wb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) wbif ();

    regfile_wb_scheduler #(.NREQ(NREQ), .DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rs3   (issue_rs3),
        .issue_use   (issue_use),
        .stall       (stall),
        .wb          (wbif.slave),
        .regwBoolean (regwBoolean),
        .rwselector  (rwselector),
        .rwdata      (rwdata),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state, kept as plain integers/arrays.
    int              m_lg;
    bit [NREG-1:0]   m_pend;
    bit              m_regw;
    int              m_sel;
    int              m_data;
    logic [NREQ-1:0] eg;
    logic            es;

    logic [NREQ-1:0] rv;
    logic [AW-1:0]   ra [NREQ];
    logic [DW-1:0]   rd [NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [NREQ-1:0] m_grant();
        logic [NREQ-1:0] g = '0;
        if (!reset) return g;
        for (int k = 1; k <= NREQ; k++) begin
            int i = (m_lg + k) % NREQ;
            if (wbif.wb_valid[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic m_stall();
        bit hit;
        hit = m_pend[issue_rd] ||
              (issue_use[0] && m_pend[issue_rs1]) ||
              (issue_use[1] && m_pend[issue_rs2]) ||
              (issue_use[2] && m_pend[issue_rs3]);
        return reset && issue_valid && hit;
    endfunction

    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) begin
            wbif.wb_valid[i]           = rv[i];
            wbif.wb_addr[i*AW +: AW]   = ra[i];
            wbif.wb_data[i*DW +: DW]   = rd[i];
        end
    endtask

    task automatic sample();
        @(negedge clk);
        eg = m_grant();
        es = m_stall();
        chk("wb_ready", 32'(wbif.wb_ready), 32'(eg));
        chk("stall", 32'(stall), 32'(es));
        chk("regw", 32'(regwBoolean), 32'(m_regw));
        chk("rwselector", 32'(rwselector), 32'(m_sel));
        chk("rwdata", 32'(rwdata), 32'(m_data));
        chk("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic step();
        if (!reset) begin
            m_lg = NREQ - 1; m_pend = '0; m_regw = 0; m_sel = 0; m_data = 0;
        end else begin
            if (m_regw) m_pend[m_sel] = 1'b0;
            if (issue_valid && !es) m_pend[issue_rd] = 1'b1;
            m_regw = (eg != '0);
            for (int i = 0; i < NREQ; i++) begin
                if (eg[i]) begin
                    m_sel  = int'(wbif.wb_addr[i*AW +: AW]);
                    m_data = int'(wbif.wb_data[i*DW +: DW]);
                    m_lg   = i;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input int rdst, input int s1, input logic [2:0] use_k);
        issue_valid = v;
        issue_rd    = AW'(rdst);
        issue_rs1   = AW'(s1);
        issue_rs2   = '0;
        issue_rs3   = '0;
        issue_use   = use_k;
    endtask

    task automatic one_req(input int i, input int a, input int d);
        rv = '0;
        if (i >= 0) begin
            rv[i] = 1'b1; ra[i] = AW'(a); rd[i] = DW'(d);
        end
        drive_req();
    endtask

    initial begin
        logic [NREQ-1:0] rr_exp [6];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        m_lg = NREQ - 1; m_pend = '0; m_regw = 0; m_sel = 0; m_data = 0;
        reset = 1'b0;
        set_issue(0, 0, 0, 3'b000);
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b1; ra[i] = AW'(10 + i); rd[i] = DW'(32'h100 * (i + 1));
        end
        drive_req();
        #1;

        // Reset held with every requester valid
        for (int c = 0; c < 2; c++) begin
            sample();
            chk("rst_ready", 32'(wbif.wb_ready), 32'h0);
            chk("rst_regw", 32'(regwBoolean), 32'h0);
            chk("rst_pending", 32'(pending), 32'h0);
            step();
        end
        reset = 1'b1;

        // Full contention rotates 0,1,2
        for (int c = 0; c < 6; c++) begin
            sample();
            chk("rr_grant", 32'(wbif.wb_ready), 32'(rr_exp[c]));
            if (c > 0) begin
                chk("rr_regw", 32'(regwBoolean), 32'h1);
                chk("rr_sel", 32'(rwselector), 32'(10 + (c - 1) % 3));
            end
            step();
        end

        // RAW on rs1 = 5, cleared by a MEM write
        one_req(-1, 0, 0);
        set_issue(1, 5, 0, 3'b000);
        sample(); chk("raw_first_stall", 32'(stall), 32'h0); step();
        set_issue(1, 6, 5, 3'b001);
        one_req(1, 5, 24'hABCDEF);
        sample();
        chk("raw_pend5", 32'(pending[5]), 32'h1);
        chk("raw_stall", 32'(stall), 32'h1);
        chk("raw_mem_grant", 32'(wbif.wb_ready), 32'h2);
        step();
        one_req(-1, 0, 0);
        sample();
        chk("raw_regw", 32'(regwBoolean), 32'h1);
        chk("raw_data", 32'(rwdata), 32'hABCDEF);
        chk("raw_stall_hold", 32'(stall), 32'h1);
        step();
        sample();
        chk("raw_pend_clr", 32'(pending[5]), 32'h0);
        chk("raw_stall_clr", 32'(stall), 32'h0);
        step();

        // WAW: back-to-back rd = 3
        set_issue(1, 3, 0, 3'b000);
        sample(); chk("waw_first", 32'(stall), 32'h0); step();
        one_req(0, 3, 24'h33);
        sample(); chk("waw_second", 32'(stall), 32'h1); step();
        one_req(-1, 0, 0);
        sample(); chk("waw_wait", 32'(stall), 32'h1); step();
        sample(); chk("waw_release", 32'(stall), 32'h0); step();

        // Set wins over same-cycle clear on rd = 7
        set_issue(0, 0, 0, 3'b000);
        one_req(0, 7, 24'h77);
        sample(); step();
        one_req(-1, 0, 0);
        set_issue(1, 7, 0, 3'b000);
        sample();
        chk("sw_regw", 32'(regwBoolean), 32'h1);
        chk("sw_sel", 32'(rwselector), 32'h7);
        chk("sw_pend_before", 32'(pending[7]), 32'h0);
        step();
        set_issue(0, 0, 0, 3'b000);
        sample(); chk("sw_pend_after", 32'(pending[7]), 32'h1); step();

        // Reset right after a transfer
        one_req(0, 4, 24'h44);
        sample(); step();
        one_req(-1, 0, 0);
        reset = 1'b0;
        sample(); step();
        sample();
        chk("mid_rst_regw", 32'(regwBoolean), 32'h0);
        chk("mid_rst_pend", 32'(pending), 32'h0);
        step();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) rv[i] = 1'b1;
        drive_req();
        sample(); chk("mid_rst_first", 32'(wbif.wb_ready), 32'h1); step();

        // Idle after a write to 9
        one_req(2, 9, 24'h000123);
        sample(); step();
        one_req(-1, 0, 0);
        sample(); step();
        for (int c = 0; c < 4; c++) begin
            sample();
            chk("idle_regw", 32'(regwBoolean), 32'h0);
            chk("idle_sel", 32'(rwselector), 32'h9);
            chk("idle_data", 32'(rwdata), 32'h000123);
            step();
        end

        // Random traffic; requesters hold their request until granted
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            issue_valid = $urandom_range(0, 1) == 1;
            issue_rd  = AW'($urandom);
            issue_rs1 = AW'($urandom);
            issue_rs2 = AW'($urandom);
            issue_rs3 = AW'($urandom);
            issue_use = 3'($urandom);
            drive_req();
            sample();
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i] || eg[i]) begin
                    rv[i] = ($urandom_range(0, 2) != 0);
                    ra[i] = AW'($urandom);
                    rd[i] = DW'($urandom);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
